// File: rtl/vcfg_unit.sv
// vcfg_unit: vector configuration unit executing vsetvli/vsetivli/vsetvl and holding architectural vl/vtype.
module vcfg_unit #(
  parameter int unsigned VLEN = 4096,
  parameter int unsigned ELEN = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] instr_i,
  input  logic [63:0] rs1_data_i,
  input  logic [63:0] rs2_data_i,
  input  logic        flush_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [4:0]  resp_rd_o,
  output logic [63:0] resp_data_o,
  output logic        resp_illegal_o,
  output logic [63:0] vl_o,
  output logic [8:0]  vtype_o,
  output logic        vstart_clr_o
);
  typedef enum logic [1:0] {IDLE, COMPUTE, RESP} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_instr;
  logic [63:0] r_rs1, r_rs2, r_vl, r_resp_data;
  logic [8:0]  r_vtype;
  logic [4:0]  r_resp_rd;
  logic        r_resp_illegal;
  logic        w_is_vli, w_is_vivli, w_is_vl, w_legal, w_vill, w_commit;
  logic [63:0] w_raw, w_avl, w_sew, w_base, w_vlmax, w_vl_new;
  logic [2:0]  w_vlmul, w_vsew, w_fshift;
  logic [8:0]  w_vtype_new;
  logic [4:0]  w_rs1, w_rd;
  always_comb begin
    w_is_vli    = ~r_instr[31];
    w_is_vivli  = r_instr[31:30] == 2'b11;
    w_is_vl     = r_instr[31:25] == 7'b1000000;
    w_legal     = r_instr[6:0] == 7'h57 && r_instr[14:12] == 3'b111 && (w_is_vli || w_is_vivli || w_is_vl);
    w_rs1       = r_instr[19:15];
    w_rd        = r_instr[11:7];
    w_raw       = w_is_vl ? r_rs2 : w_is_vivli ? {54'd0, r_instr[29:20]} : {53'd0, r_instr[30:20]};
    w_vlmul     = w_raw[2:0];
    w_vsew      = w_raw[5:3];
    w_fshift    = 3'd0 - w_vlmul;
    w_sew       = 64'd8 << w_vsew;
    w_vill      = (|w_raw[63:8]) || w_sew > 64'(ELEN) || w_vlmul == 3'b100 ||
                  (w_vlmul[2] && w_sew > (64'(ELEN) >> w_fshift));
    w_base      = 64'(VLEN / 8) >> w_vsew;
    w_vlmax     = w_vlmul[2] ? w_base >> w_fshift : w_base << w_vlmul[1:0];
    w_avl       = w_is_vivli ? {59'd0, r_instr[19:15]} : r_rs1;
    w_vl_new    = w_vill ? 64'd0 :
                  (w_is_vivli || w_rs1 != 5'd0) ? (w_avl < w_vlmax ? w_avl : w_vlmax) :
                  (w_rd != 5'd0) ? w_vlmax :
                  (r_vl < w_vlmax ? r_vl : w_vlmax);
    w_vtype_new = w_vill ? 9'h100 : {1'b0, w_raw[7:0]};
  end
  always_comb begin
    w_next       = r_state == IDLE    ? (req_valid_i ? COMPUTE : IDLE) :
                   r_state == COMPUTE ? (flush_i ? IDLE : RESP) :
                   (resp_ready_i || flush_i) ? IDLE : RESP;
    w_commit     = r_state == COMPUTE && !flush_i && w_legal;
    req_ready_o  = r_state == IDLE;
    resp_valid_o = r_state == RESP;
    vstart_clr_o = w_commit;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_instr        <= '0;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_vl           <= '0;
      r_vtype        <= 9'h100;
      r_resp_rd      <= '0;
      r_resp_data    <= '0;
      r_resp_illegal <= 1'b0;
    end else begin
      if (req_valid_i && req_ready_o) begin
        r_instr <= instr_i;
        r_rs1   <= rs1_data_i;
        r_rs2   <= rs2_data_i;
      end
      if (r_state == COMPUTE && !flush_i) begin
        r_resp_rd      <= w_rd;
        r_resp_illegal <= !w_legal;
        r_resp_data    <= w_legal ? w_vl_new : 64'd0;
      end
      if (w_commit) begin
        r_vl    <= w_vl_new;
        r_vtype <= w_vtype_new;
      end
    end
  end
  assign vl_o           = r_vl;
  assign vtype_o        = r_vtype;
  assign resp_rd_o      = r_resp_rd;
  assign resp_data_o    = r_resp_data;
  assign resp_illegal_o = r_resp_illegal;
endmodule

// File: tb/tb_vcfg_unit.sv
// tb_vcfg_unit: directed checks of vcfg_unit at VLEN=4096, ELEN=64.
module tb_vcfg_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] instr = '0;
  logic [63:0] rs1_data = '0, rs2_data = '0;
  logic        flush = 1'b0;
  logic        resp_valid, resp_ready = 1'b0;
  logic [4:0]  resp_rd;
  logic [63:0] resp_data, vl;
  logic        resp_illegal, vstart_clr;
  logic [8:0]  vtype;
  int          n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  vcfg_unit #(.VLEN(4096), .ELEN(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .instr_i(instr), .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .flush_i(flush),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rd_o(resp_rd),
    .resp_data_o(resp_data), .resp_illegal_o(resp_illegal), .vl_o(vl),
    .vtype_o(vtype), .vstart_clr_o(vstart_clr)
  );

  function automatic logic [31:0] vsetvli(input logic [4:0] rd, input logic [4:0] rs1, input logic [10:0] z);
    return {1'b0, z, rs1, 3'b111, rd, 7'h57};
  endfunction
  function automatic logic [31:0] vsetivli(input logic [4:0] rd, input logic [4:0] u, input logic [9:0] z);
    return {2'b11, z, u, 3'b111, rd, 7'h57};
  endfunction
  function automatic logic [31:0] vsetvl(input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1);
    return {f7, 5'd3, rs1, 3'b111, rd, 7'h57};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    req_valid = 1'b1; instr = i; rs1_data = a; rs2_data = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic [31:0] i, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] e_vl, input logic [8:0] e_vt, input logic [4:0] e_rd, input logic e_ill);
    offer(i, a, b);
    chk({tag, " clr"}, vstart_clr, !e_ill);
    chk({tag, " busy"}, req_ready, 0);
    chk({tag, " early"}, resp_valid, 0);
    @(negedge clk);
    chk({tag, " valid"}, resp_valid, 1);
    chk({tag, " data"}, resp_data, e_ill ? 64'd0 : e_vl);
    chk({tag, " rd"}, resp_rd, e_rd);
    chk({tag, " ill"}, resp_illegal, e_ill);
    chk({tag, " vl"}, vl, e_vl);
    chk({tag, " vtype"}, vtype, e_vt);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, " done"}, resp_valid, 0);
    chk({tag, " ready"}, req_ready, 1);
  endtask

  initial begin
    #12;
    chk("rst vl", vl, 0);
    chk("rst vtype", vtype, 9'h100);
    chk("rst valid", resp_valid, 0);
    chk("rst clr", vstart_clr, 0);
    @(negedge clk) rst_n = 1'b1;
    chk("rst ready", req_ready, 1);

    run("e32m1 avl100", vsetvli(5'd1, 5'd2, 11'h010), 64'd100, 0, 64'd100, 9'h010, 5'd1, 0);
    chk("vsew ew32", vtype[5:3], 3'b010);
    run("e32m1 avl1000", vsetvli(5'd1, 5'd2, 11'h010), 64'd1000, 0, 64'd128, 9'h010, 5'd1, 0);
    run("e64m8 x0 rd5", vsetvli(5'd5, 5'd0, 11'h01B), 64'd7, 0, 64'd512, 9'h01B, 5'd5, 0);
    run("e64m1 keep vl", vsetvli(5'd0, 5'd0, 11'h018), 64'd7, 0, 64'd64, 9'h018, 5'd0, 0);
    run("ivli e8mf8", vsetivli(5'd3, 5'd5, 10'h005), 64'd999, 0, 64'd5, 9'h005, 5'd3, 0);
    run("ivli e64mf8", vsetivli(5'd3, 5'd5, 10'h01D), 64'd999, 0, 64'd0, 9'h100, 5'd3, 0);
    run("e16mf2 ta ma", vsetvli(5'd4, 5'd6, 11'h0CF), 64'd1000, 0, 64'd128, 9'h0CF, 5'd4, 0);
    run("vsetvl e64m1", vsetvl(7'b1000000, 5'd7, 5'd8), 64'd30, 64'h18, 64'd30, 9'h018, 5'd7, 0);
    run("vsetvl bit8", vsetvl(7'b1000000, 5'd7, 5'd8), 64'd30, 64'h110, 64'd0, 9'h100, 5'd7, 0);
    run("e32m1 again", vsetvli(5'd1, 5'd2, 11'h010), 64'd100, 0, 64'd100, 9'h010, 5'd1, 0);
    run("bad func7", vsetvl(7'b1000001, 5'd9, 5'd8), 64'd30, 64'h18, 64'd100, 9'h010, 5'd9, 1);
    run("bad opcode", vsetvli(5'd1, 5'd2, 11'h010) ^ 32'h1, 64'd40, 0, 64'd100, 9'h010, 5'd1, 1);

    offer(vsetvli(5'd9, 5'd2, 11'h000), 64'd7, 0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("hold valid", resp_valid, 1);
      chk("hold data", resp_data, 64'd7);
      chk("hold rd", resp_rd, 5'd9);
      chk("hold ready", req_ready, 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("hold done", resp_valid, 0);

    offer(vsetvli(5'd9, 5'd2, 11'h000), 64'd50, 0);
    flush = 1'b1;
    #1 chk("flush clr", vstart_clr, 0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush idle", req_ready, 1);
    chk("flush noresp", resp_valid, 0);
    chk("flush vl", vl, 64'd7);
    @(negedge clk);
    chk("flush noresp2", resp_valid, 0);

    offer(vsetvli(5'd9, 5'd2, 11'h000), 64'd60, 0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("rflush drop", resp_valid, 0);
    chk("rflush vl", vl, 64'd60);
    chk("rflush ready", req_ready, 1);

    offer(vsetvli(5'd9, 5'd2, 11'h018), 64'd20, 0);
    rst_n = 1'b0;
    #1;
    chk("arst vl", vl, 0);
    chk("arst vtype", vtype, 9'h100);
    chk("arst vill", vtype[8], 1);
    chk("arst valid", resp_valid, 0);
    chk("arst data", resp_data, 0);
    chk("arst rd", resp_rd, 0);
    chk("arst ill", resp_illegal, 0);
    chk("arst clr", vstart_clr, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("arst ready", req_ready, 1);
    chk("arst stay", resp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/vcfg_unit.md
VCFG_UNIT -- requirements
Module: vcfg_unit

Interface
REQ-001 SHALL have parameter VLEN, default 4096, vector register length in bits (power of two, 128..RISCV_MAX_VLEN).
REQ-002 SHALL have parameter ELEN, default 64, maximum supported element width in bits.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid_i  input  1  config instruction offered.
REQ-006 SHALL have port req_ready_o  output  1  unit accepts instruction.
REQ-007 SHALL have port instr_i  input  32  instruction word, decoded as rvv_instruction_t.
REQ-008 SHALL have port rs1_data_i  input  64  AVL operand (scalar x[rs1]).
REQ-009 SHALL have port rs2_data_i  input  64  vtype operand for vsetvl.
REQ-010 SHALL have port flush_i  input  1  abort an in-flight, uncommitted instruction.
REQ-011 SHALL have port resp_valid_o  output  1  result available.
REQ-012 SHALL have port resp_ready_i  input  1  consumer takes result.
REQ-013 SHALL have port resp_rd_o  output  5  destination register index.
REQ-014 SHALL have port resp_data_o  output  64  new vl, zero-extended, written to rd.
REQ-015 SHALL have port resp_illegal_o  output  1  instruction not a legal OPCFG encoding.
REQ-016 SHALL have port vl_o  output  64  architectural vl.
REQ-017 SHALL have port vtype_o  output  9  architectural vtype as vtype_t.
REQ-018 SHALL have port vstart_clr_o  output  1  one-cycle pulse clearing vstart on commit.

Function
REQ-019 SHALL implement FSM IDLE -> COMPUTE -> RESP -> IDLE; req_ready_o = 1 only in IDLE.
REQ-020 SHALL capture instr/rs1/rs2 on req_valid_i&&req_ready_o and enter COMPUTE next cycle.
REQ-021 SHALL decode: opcode 7'h57 with func3=OPCFG required; bit31=0 vsetvli (vtype=zimm11, AVL=rs1_data_i); bits31:30=2'b11 vsetivli (vtype=zimm10, AVL=uimm5 zero-extended); bits31:25=7'b1000000 vsetvl (vtype=rs2_data_i); anything else illegal.
REQ-022 SHALL map raw vtype bits [2:0] vlmul, [5:3] vsew, [6] vta, [7] vma; any nonzero higher bit sets vill.
REQ-023 SHALL set vill when vsew encodes SEW>ELEN, vlmul=LMUL_RSVD, or fractional LMUL with SEW>ELEN*LMUL.
REQ-024 SHALL compute VLMAX=(VLEN/8>>vsew) shifted left by vlmul for LMUL_1..LMUL_8, right by (8-vlmul) for fractional codes.
REQ-025 SHALL set vl: vsetivli or rs1!=x0 -> min(AVL,VLMAX); rs1=x0,rd!=x0 -> VLMAX; rs1=x0,rd=x0 -> min(current vl,VLMAX).
REQ-026 SHALL, on vill, commit vtype = {vill=1, all other fields 0} and vl=0.
REQ-027 SHALL commit vl_o/vtype_o at end of COMPUTE and pulse vstart_clr_o during that cycle; new values visible the cycle resp_valid_o rises.
REQ-028 SHALL, for illegal instructions, not update vl_o/vtype_o, not pulse vstart_clr_o, and respond with resp_illegal_o=1, resp_data_o=0.
REQ-029 SHALL hold resp_valid_o and all resp_* stable in RESP until resp_ready_i; return to IDLE on handshake (next accept one cycle later).
REQ-030 SHALL drive resp_data_o = committed vl, resp_rd_o = instr rd.
REQ-031 SHALL, on flush_i in COMPUTE, discard without commit or pulse and go to IDLE; flush_i in RESP drops the response (state stays committed); flush_i ignored in IDLE.
REQ-032 SHALL yield minimum latency of 2 cycles from accept to resp_valid_o.

Reset
REQ-033 SHALL on rst_ni low, regardless of state: FSM=IDLE, vl_o=0, vtype_o={vill=1, rest 0}, resp_valid_o=0, resp_illegal_o=0, resp_data_o=0, resp_rd_o=0, vstart_clr_o=0; req_ready_o=1 after release.

Verification (VLEN=4096, ELEN=64)
REQ-034 SHALL cover: vsetvli e32,m1, rs1!=x0, AVL=100 -> vl_o=100, resp_data_o=100, vtype_o.vsew=EW32; AVL=1000 -> vl_o=128.
REQ-035 SHALL cover: vsetvli e64,m8, rs1=x0, rd=x5 -> vl_o=512, resp_rd_o=5; then rs1=x0, rd=x0 with e64,m1 -> vl_o=64.
REQ-036 SHALL cover: vsetivli uimm=5, e8,mf8 -> vl_o=5 (VLMAX=64); e64,mf8 -> vtype_o.vill=1, vl_o=0.
REQ-037 SHALL cover: vsetvl with rs2_data_i bit 8 set -> vill=1, vl_o=0; func7=7'b1000001 -> resp_illegal_o=1, vl_o/vtype_o unchanged.
REQ-038 SHALL cover: resp_ready_i low 3 cycles -> resp_* stable, req_ready_o=0; flush_i in COMPUTE -> no resp, vl_o unchanged.
REQ-039 SHALL cover: rst_ni asserted during COMPUTE -> all outputs at reset values immediately, vtype_o.vill=1.
